psic_cal_engine: RTL

Multi-channel calibration engine, the parametrised successor to the single-channel pressure-sensor correction datapath.
- Holds per-channel Tco, Offset and Gain coefficients and accepts opcoded write, read and readback commands from the serial command decoder.
- Sequences pressure and PTAT conversions through the A2D interface.
- Returns a saturated result: corrected = sat(Gain·(P + Offset + Tco·PTAT)).
- New over the previous generation: NUM_CH channels, raw-bypass and coefficient-readback modes, busy/illegal-command rejection, and an A2D timeout.

---
 rtl/psic_cal_engine_if.sv | 31 +++
 rtl/psic_cal_engine.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psic_cal_engine_if.sv
// Command / response / A2D bundle for psic_cal_engine.
// master: command decoder + A2D converter side; slave: the calibration engine.
interface psic_cal_if #(
    parameter int DATA_W = 16
);
    // command side
    logic              cmd_vld;
    logic [2:0]        cmd_op;
    logic [2:0]        cmd_ch;
    logic [DATA_W-1:0] cmd_data;
    // response side
    logic              rsp_vld;
    logic [DATA_W-1:0] rsp_data;
    logic              cmd_err;
    logic              busy;
    // A2D converter side
    logic              a2d_strt;
    logic [3:0]        a2d_sel;
    logic              a2d_cmplt;
    logic [DATA_W-1:0] a2d_res;

    modport master (
        output cmd_vld, cmd_op, cmd_ch, cmd_data, a2d_cmplt, a2d_res,
        input  rsp_vld, rsp_data, cmd_err, busy, a2d_strt, a2d_sel
    );

    modport slave (
        input  cmd_vld, cmd_op, cmd_ch, cmd_data, a2d_cmplt, a2d_res,
        output rsp_vld, rsp_data, cmd_err, busy, a2d_strt, a2d_sel
    );
endinterface

// File: rtl/psic_cal_engine.sv
// Multi-channel pressure sensor calibration engine.
// Per channel it stores Tco, Offset and Gain (signed Q2.(DATA_W-2)) and
// answers corrected reads with sat(Gain * (P + Offset + Tco * PTAT)),
// raw reads with P, and coefficient readbacks. One shared multiplier is
// time-multiplexed between the Tco and Gain products.
module psic_cal_engine #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16,
    parameter int TO_CYC = 1024
) (
    input  logic     clk,
    input  logic     rst,
    psic_cal_if.slave bus
);
    localparam int FRAC   = DATA_W - 2;
    localparam int SUM_W  = DATA_W + 3;
    localparam int PROD_W = DATA_W + SUM_W;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CH_N   = 1 << CH_W;
    localparam int CNT_W  = $clog2(TO_CYC + 1);

    localparam logic signed [DATA_W-1:0] UNITY   = {2'b01, {FRAC{1'b0}}};
    localparam logic signed [PROD_W-1:0] SAT_MAX =
        {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_MIN =
        {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    localparam logic [2:0] OP_CORR    = 3'd0;
    localparam logic [2:0] OP_RAW     = 3'd1;
    localparam logic [2:0] OP_RDBK    = 3'd2;
    localparam logic [2:0] OP_WR_TCO  = 3'd5;
    localparam logic [2:0] OP_WR_OFF  = 3'd6;
    localparam logic [2:0] OP_WR_GAIN = 3'd7;

    typedef enum logic [3:0] {
        S_IDLE, S_WR, S_RD_COEF, S_STRT_P, S_WAIT_P,
        S_STRT_T, S_WAIT_T, S_MUL_T, S_MUL_G, S_RESP
    } state_e;

    state_e                    state_q;
    logic [2:0]                op_q;
    logic [2:0]                ch_q;
    logic [DATA_W-1:0]         data_q;
    logic signed [DATA_W-1:0]  p_q;
    logic signed [DATA_W-1:0]  ptat_q;
    logic signed [SUM_W-1:0]   sum_q;
    logic [CNT_W-1:0]          to_cnt_q;

    logic                      rsp_vld_q;
    logic [DATA_W-1:0]         rsp_data_q;
    logic                      cmd_err_q;
    logic                      busy_q;
    logic                      a2d_strt_q;
    logic [3:0]                a2d_sel_q;

    // Storage is rounded up to a power of two so the channel index needs no
    // range guard; only legal channels are ever written or read.
    logic signed [DATA_W-1:0]  tco_q  [CH_N];
    logic signed [DATA_W-1:0]  off_q  [CH_N];
    logic signed [DATA_W-1:0]  gain_q [CH_N];

    logic [CH_W-1:0]           ch_idx;
    logic [CH_W-1:0]           cmd_idx;
    logic                      cmd_legal;
    logic signed [DATA_W-1:0]  coef_sel;
    logic signed [DATA_W-1:0]  mul_a;
    logic signed [SUM_W-1:0]   mul_b;
    logic signed [PROD_W-1:0]  prod;
    logic signed [PROD_W-1:0]  prod_sh;
    logic signed [SUM_W-1:0]   sum_d;
    logic signed [DATA_W-1:0]  sat_d;

    assign ch_idx  = ch_q[CH_W-1:0];
    assign cmd_idx = bus.cmd_ch[CH_W-1:0];

    // Legality of the command presented on the bus this cycle.
    always_comb begin
        cmd_legal = 1'b1;
        if ({29'd0, bus.cmd_ch} >= 32'(NUM_CH)) begin
            cmd_legal = 1'b0;
        end
        case (bus.cmd_op)
            3'd3, 3'd4: cmd_legal = 1'b0;
            OP_RDBK:    if (bus.cmd_data[1:0] == 2'd0) cmd_legal = 1'b0;
            default:    ;
        endcase
    end

    // Coefficient selected by a readback command (select 0 never gets here).
    always_comb begin
        case (data_q[1:0])
            2'd1:    coef_sel = tco_q[ch_idx];
            2'd2:    coef_sel = off_q[ch_idx];
            default: coef_sel = gain_q[ch_idx];
        endcase
    end

    // Shared multiplier: Tco*PTAT in MUL_T, Gain*sum in MUL_G; floor shifts.
    always_comb begin
        mul_a   = tco_q[ch_idx];
        mul_b   = {{3{ptat_q[DATA_W-1]}}, ptat_q};
        if (state_q == S_MUL_G) begin
            mul_a = gain_q[ch_idx];
            mul_b = sum_q;
        end
        prod    = PROD_W'(mul_a) * PROD_W'(mul_b);
        prod_sh = prod >>> FRAC;
        sum_d   = {{3{p_q[DATA_W-1]}}, p_q}
                + {{3{off_q[ch_idx][DATA_W-1]}}, off_q[ch_idx]}
                + prod_sh[SUM_W-1:0];
        if (prod_sh > SAT_MAX) begin
            sat_d = SAT_MAX[DATA_W-1:0];
        end else if (prod_sh < SAT_MIN) begin
            sat_d = SAT_MIN[DATA_W-1:0];
        end else begin
            sat_d = prod_sh[DATA_W-1:0];
        end
    end

    // Control FSM with registered outputs, coefficient store and datapath regs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            ch_q       <= '0;
            data_q     <= '0;
            p_q        <= '0;
            ptat_q     <= '0;
            sum_q      <= '0;
            to_cnt_q   <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
            cmd_err_q  <= 1'b0;
            busy_q     <= 1'b0;
            a2d_strt_q <= 1'b0;
            a2d_sel_q  <= '0;
            for (int i = 0; i < CH_N; i++) begin
                tco_q[i]  <= '0;
                off_q[i]  <= '0;
                gain_q[i] <= UNITY;
            end
        end else begin
            rsp_vld_q  <= 1'b0;
            cmd_err_q  <= 1'b0;
            a2d_strt_q <= 1'b0;

            // Any command arriving outside IDLE is dropped and flagged.
            if (bus.cmd_vld && state_q != S_IDLE) begin
                cmd_err_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.cmd_vld) begin
                        if (!cmd_legal) begin
                            cmd_err_q <= 1'b1;
                        end else begin
                            op_q   <= bus.cmd_op;
                            ch_q   <= bus.cmd_ch;
                            data_q <= bus.cmd_data;
                            busy_q <= 1'b1;
                            // Writes land at acceptance so the new value is
                            // live from the following cycle; WR only echoes.
                            case (bus.cmd_op)
                                OP_WR_TCO: begin
                                    tco_q[cmd_idx] <= bus.cmd_data;
                                    state_q        <= S_WR;
                                end
                                OP_WR_OFF: begin
                                    off_q[cmd_idx] <= bus.cmd_data;
                                    state_q        <= S_WR;
                                end
                                OP_WR_GAIN: begin
                                    gain_q[cmd_idx] <= bus.cmd_data;
                                    state_q         <= S_WR;
                                end
                                OP_RDBK: state_q <= S_RD_COEF;
                                default: begin
                                    state_q    <= S_STRT_P;
                                    a2d_strt_q <= 1'b1;
                                    a2d_sel_q  <= {bus.cmd_ch, 1'b0};
                                end
                            endcase
                        end
                    end
                end
                S_WR: begin
                    rsp_data_q <= data_q;
                    rsp_vld_q  <= 1'b1;
                    state_q    <= S_RESP;
                end
                // Loads the result register: coefficient, or P for a raw read.
                S_RD_COEF: begin
                    rsp_data_q <= (op_q == OP_RAW) ? p_q : coef_sel;
                    rsp_vld_q  <= 1'b1;
                    state_q    <= S_RESP;
                end
                S_STRT_P: begin
                    to_cnt_q <= '0;
                    state_q  <= S_WAIT_P;
                end
                S_WAIT_P: begin
                    if (bus.a2d_cmplt) begin
                        p_q <= bus.a2d_res;
                        if (op_q == OP_RAW) begin
                            state_q <= S_RD_COEF;
                        end else begin
                            state_q    <= S_STRT_T;
                            a2d_strt_q <= 1'b1;
                            a2d_sel_q  <= {ch_q, 1'b1};
                        end
                    end else if (to_cnt_q == CNT_W'(TO_CYC - 1)) begin
                        cmd_err_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + CNT_W'(1);
                    end
                end
                S_STRT_T: begin
                    to_cnt_q <= '0;
                    state_q  <= S_WAIT_T;
                end
                S_WAIT_T: begin
                    if (bus.a2d_cmplt) begin
                        ptat_q  <= bus.a2d_res;
                        state_q <= S_MUL_T;
                    end else if (to_cnt_q == CNT_W'(TO_CYC - 1)) begin
                        cmd_err_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + CNT_W'(1);
                    end
                end
                S_MUL_T: begin
                    sum_q   <= sum_d;
                    state_q <= S_MUL_G;
                end
                S_MUL_G: begin
                    rsp_data_q <= sat_d;
                    rsp_vld_q  <= 1'b1;
                    state_q    <= S_RESP;
                end
                S_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_vld  = rsp_vld_q;
    assign bus.rsp_data = rsp_data_q;
    assign bus.cmd_err  = cmd_err_q;
    assign bus.busy     = busy_q;
    assign bus.a2d_strt = a2d_strt_q;
    assign bus.a2d_sel  = a2d_sel_q;

    // op_q values other than raw steer only through the state sequence.
    logic unused_ok;
    assign unused_ok = &{1'b0, (op_q == OP_CORR)};
endmodule
